// File: rtl/dbus_mem_responder.sv
// Single-port 64-bit data-bus memory responder with a fixed response latency.
// One transaction in flight: IDLE -> WAIT (LATENCY cycles) -> RESP -> IDLE.
module dbus_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dreq_valid,
    input  logic [63:0] dreq_addr,
    input  logic [2:0]  dreq_size,
    input  logic [7:0]  dreq_strobe,
    input  logic [63:0] dreq_data,
    output logic        dresp_addr_ok,
    output logic        dresp_data_ok,
    output logic [63:0] dresp_data,
    output logic        err,
    output logic [31:0] txn_count
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            cap;
    logic [AW-1:0]   idx_q;
    logic [2:0]      off_q;
    logic [2:0]      size_q;
    logic [7:0]      strb_q;
    logic [63:0]     wdata_q;
    logic [31:0]     txn_q;
    logic [63:0]     mem_q [DEPTH];

    logic            in_resp;
    logic            misalign;
    logic            illegal;
    logic [7:0]      lane_base;
    logic [7:0]      lane_mask;

    // Address bits above the word index wrap around and are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^dreq_addr[63:AW+3];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dreq_valid) begin
                    cap = 1'b1;
                    if (LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            off_q   <= '0;
            size_q  <= '0;
            strb_q  <= '0;
            wdata_q <= '0;
            txn_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (cap) begin
                idx_q   <= dreq_addr[3 +: AW];
                off_q   <= dreq_addr[2:0];
                size_q  <= dreq_size;
                strb_q  <= dreq_strobe;
                wdata_q <= dreq_data;
            end
            if (in_resp && txn_q != 32'hFFFF_FFFF) txn_q <= txn_q + 32'd1;
        end
    end

    always_comb begin
        unique case (size_q)
            3'd0:    begin lane_base = 8'h01; misalign = 1'b0;       end
            3'd1:    begin lane_base = 8'h03; misalign = off_q[0];   end
            3'd2:    begin lane_base = 8'h0F; misalign = |off_q[1:0]; end
            3'd3:    begin lane_base = 8'hFF; misalign = |off_q;     end
            default: begin lane_base = 8'h00; misalign = 1'b1;       end
        endcase
        lane_mask = lane_base << off_q;
        illegal   = size_q[2] | misalign | (|(strb_q & ~lane_mask));
    end

    assign in_resp       = (state_q == RESP);
    assign dresp_addr_ok = in_resp;
    assign dresp_data_ok = in_resp;
    assign err           = in_resp & illegal;
    assign dresp_data    = (in_resp && !illegal && strb_q == 8'h00) ? mem_q[idx_q] : 64'h0;
    assign txn_count     = txn_q;

    // Commit on the edge that ends RESP; reset drops state to IDLE, which aborts it.
    always_ff @(posedge clk) begin
        if (in_resp && !illegal && |strb_q) begin
            for (int i = 0; i < 8; i++) begin
                if (strb_q[i]) mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end
endmodule

// File: doc/dbus_mem_responder.md
DBUS_MEM_RESPONDER -- requirements
Module: dbus_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256: number of 64-bit memory words, power of two, 2..4096.
REQ-002 SHALL have parameter LATENCY, default 2: wait cycles between request accept and response, 0..15.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port dreq_valid  input  1: request present; the requester holds it and all request fields stable until dresp_data_ok.
REQ-006 SHALL have port dreq_addr  input  64: byte address.
REQ-007 SHALL have port dreq_size  input  3: access size; 0 = byte, 1 = half, 2 = word, 3 = dword; 4..7 illegal.
REQ-008 SHALL have port dreq_strobe  input  8: byte-lane write enables; 0 means read.
REQ-009 SHALL have port dreq_data  input  64: write data, lane-aligned.
REQ-010 SHALL have port dresp_addr_ok  output  1: request address accepted.
REQ-011 SHALL have port dresp_data_ok  output  1: transaction complete.
REQ-012 SHALL have port dresp_data  output  64: read data, full aligned dword.
REQ-013 SHALL have port err  output  1: one-cycle pulse with dresp_data_ok when the completed request was illegal.
REQ-014 SHALL have port txn_count  output  32: number of completed transactions, saturating.

Function
REQ-015 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-016 In IDLE with dreq_valid=1 at an edge, SHALL capture addr, size, strobe and data, load the wait counter with LATENCY, and go to WAIT; if LATENCY=0, go directly to RESP.
REQ-017 In WAIT SHALL decrement the counter each cycle and go to RESP on the edge where the counter reaches 0.
REQ-018 Timing: a request accepted at edge T SHALL see dresp_addr_ok=dresp_data_ok=1 for exactly the one cycle following edge T+LATENCY.
REQ-019 In RESP SHALL return to IDLE unconditionally; back-to-back requests are therefore separated by at least one IDLE cycle.
REQ-020 Word index SHALL be addr[3 +: log2(DEPTH)]; higher address bits are ignored (wrap-around).
REQ-021 A request SHALL be illegal when size>3, or addr is not aligned to 2^size bytes, or (strobe!=0 and strobe has bits outside the lanes covered by addr[2:0] and size).
REQ-022 A legal write (strobe!=0) SHALL update only the enabled byte lanes at the edge ending the RESP cycle; dresp_data during RESP SHALL be 0.
REQ-023 A legal read (strobe==0) SHALL drive the full aligned dword in dresp_data during RESP, valid only while dresp_data_ok=1; the response carries no sign or zero extension.
REQ-024 An illegal request SHALL complete with normal timing, drive dresp_data=0 and err=1, and SHALL NOT modify memory.
REQ-025 A read immediately following a write to the same word SHALL return the updated data.
REQ-026 dreq_valid deasserting in WAIT (protocol violation) SHALL be ignored; the captured transaction completes.
REQ-027 txn_count SHALL increment on every RESP cycle, including illegal requests, and hold at 0xFFFF_FFFF.
REQ-028 dresp_addr_ok, dresp_data_ok and err SHALL be 0 in IDLE and WAIT.

Reset
REQ-029 When rst is low, SHALL immediately force state=IDLE, counter=0, dresp_addr_ok=0, dresp_data_ok=0, dresp_data=0, err=0 and txn_count=0, without waiting for a clock edge.
REQ-030 Reset asserted during WAIT or RESP SHALL abort the transaction: no write commit and no response.
REQ-031 Memory contents SHALL NOT be affected by reset; memory contents before the first write are undefined.
REQ-032 After rst is released, the first request SHALL be accepted at the first edge at which dreq_valid=1.

Verification
REQ-033 LATENCY=2: write addr 0x10, size 3, strobe 0xFF, data 0x1122334455667788, accepted at edge T -> data_ok high after edge T+2 only; then read addr 0x10 -> dresp_data 0x1122334455667788, txn_count=2.
REQ-034 Byte write addr 0x13, size 0, strobe 0x08, data 0x00000000AB000000 over the dword from REQ-033 -> read addr 0x10 returns 0x11223344AB667788.
REQ-035 Misaligned access (addr 0x11, size 1, strobe 0x06) -> err=1 with data_ok and dresp_data=0; a following read of addr 0x10 returns the memory unchanged.
REQ-036 DEPTH=256: write to addr 0x800 -> read of addr 0x0 returns the written data (wrap-around).
REQ-037 LATENCY=0 back-to-back reads -> data_ok on every second cycle, with one IDLE cycle between responses.
REQ-038 rst pulled low during WAIT of a write -> outputs immediately 0, no data_ok; a later read returns the prior memory value.
